// File: rtl/axi_lite_cmd_arbiter.sv
// axi_lite_cmd_arbiter
// Shares one AXI-Lite master command interface between two requesters.
// Each request moves through four states: it is granted, then issued as a
// one-cycle command, then waits for completion or timeout, then returns its
// result with a one-cycle done pulse.
// Optional macro ARB_ROUND_ROBIN_EN: when both ports request together, the
// port that was not granted last wins. Without the macro, port 0 always wins.
// Every output is registered.
module axi_lite_cmd_arbiter #(
    parameter int          ADDR_W         = 8,
    parameter int          DATA_W         = 8,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [3:0]  TIMEOUT_RESP   = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [3:0]        resp,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_raddr,
    output logic [ADDR_W-1:0] m_waddr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_rd_done,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_wr_done,
    input  logic [3:0]        m_resp,
    output logic              busy
);

    // The timer must hold TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic              sel, sel_nxt;            // granted port: 0 or 1
    logic              cmd_we, cmd_we_nxt;
    logic [ADDR_W-1:0] cmd_addr, cmd_addr_nxt;
    logic [DATA_W-1:0] cmd_wdata, cmd_wdata_nxt;

    logic              gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic [3:0]        resp_nxt;
    logic              m_read_nxt, m_write_nxt;
    logic [ADDR_W-1:0] m_raddr_nxt, m_waddr_nxt;
    logic [DATA_W-1:0] m_wdata_nxt;
    logic              busy_nxt;
    logic              win;

`ifdef ARB_ROUND_ROBIN_EN
    logic              last_grant, last_grant_nxt;
`endif

    // Compute the next state and the next value of every registered output.
    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        sel_nxt       = sel;
        cmd_we_nxt    = cmd_we;
        cmd_addr_nxt  = cmd_addr;
        cmd_wdata_nxt = cmd_wdata;
        gnt0_nxt      = gnt0;
        gnt1_nxt      = gnt1;
        done0_nxt     = 1'b0;
        done1_nxt     = 1'b0;
        rdata_nxt     = rdata;
        resp_nxt      = resp;
        m_read_nxt    = 1'b0;
        m_write_nxt   = 1'b0;
        m_raddr_nxt   = '0;
        m_waddr_nxt   = '0;
        m_wdata_nxt   = '0;
        win           = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_nxt = last_grant;
`endif

        unique case (state)
            S_IDLE: begin
                if (req0 || req1) begin
`ifdef ARB_ROUND_ROBIN_EN
                    win = (req0 && req1) ? ~last_grant : req1;
`else
                    win = ~req0;
`endif
                    sel_nxt       = win;
                    cmd_we_nxt    = win ? we1    : we0;
                    cmd_addr_nxt  = win ? addr1  : addr0;
                    cmd_wdata_nxt = win ? wdata1 : wdata0;
                    gnt0_nxt      = ~win;
                    gnt1_nxt      = win;
                    state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                m_read_nxt  = ~cmd_we;
                m_write_nxt = cmd_we;
                if (cmd_we) begin
                    m_waddr_nxt = cmd_addr;
                    m_wdata_nxt = cmd_wdata;
                end else begin
                    m_raddr_nxt = cmd_addr;
                end
                timer_nxt = TW'(TIMEOUT_CYCLES - 1);
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Completion takes precedence over a timer that has just expired.
                if (!cmd_we && m_rd_done) begin
                    rdata_nxt = m_rdata;
                    resp_nxt  = 4'h0;
                    state_nxt = S_DONE;
                end else if (cmd_we && m_wr_done) begin
                    rdata_nxt = '0;
                    resp_nxt  = m_resp;
                    state_nxt = S_DONE;
                end else if (timer == '0) begin
                    rdata_nxt = '0;
                    resp_nxt  = TIMEOUT_RESP;
                    state_nxt = S_DONE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
                if (state_nxt == S_DONE) begin
                    done0_nxt = ~sel;
                    done1_nxt = sel;
                end
            end
            S_DONE: begin
                gnt0_nxt  = 1'b0;
                gnt1_nxt  = 1'b0;
                rdata_nxt = '0;
                resp_nxt  = 4'h0;
`ifdef ARB_ROUND_ROBIN_EN
                last_grant_nxt = sel;
`endif
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // State, command latch and registered outputs; synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            sel       <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata     <= '0;
            resp      <= 4'h0;
            m_read    <= 1'b0;
            m_write   <= 1'b0;
            m_raddr   <= '0;
            m_waddr   <= '0;
            m_wdata   <= '0;
            busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            sel       <= sel_nxt;
            cmd_we    <= cmd_we_nxt;
            cmd_addr  <= cmd_addr_nxt;
            cmd_wdata <= cmd_wdata_nxt;
            gnt0      <= gnt0_nxt;
            gnt1      <= gnt1_nxt;
            done0     <= done0_nxt;
            done1     <= done1_nxt;
            rdata     <= rdata_nxt;
            resp      <= resp_nxt;
            m_read    <= m_read_nxt;
            m_write   <= m_write_nxt;
            m_raddr   <= m_raddr_nxt;
            m_waddr   <= m_waddr_nxt;
            m_wdata   <= m_wdata_nxt;
            busy      <= busy_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= last_grant_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Testbench for axi_lite_cmd_arbiter (TIMEOUT_CYCLES = 8).
// The bench plays both requesters and the AXI-Lite master. A
// transaction-level model predicts the winner, command contents, done
// cycle and returned data. Honours ARB_ROUND_ROBIN_EN like the DUT.
module tb_axi_lite_cmd_arbiter;

    localparam int         TO   = 8;
    localparam logic [3:0] TRSP = 4'hF;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1;
    logic [7:0] rdata;
    logic [3:0] resp;
    logic       m_read, m_write;
    logic [7:0] m_raddr, m_waddr, m_wdata;
    logic       m_rd_done, m_wr_done;
    logic [7:0] m_rdata;
    logic [3:0] m_resp;
    logic       busy;

    int vec_cnt = 0;
    int err_cnt = 0;
    bit last_m  = 1'b1;   // model of the most recently granted port

    always #5 clk = ~clk;

    axi_lite_cmd_arbiter #(
        .ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TO), .TIMEOUT_RESP(TRSP)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .resp(resp),
        .m_read(m_read), .m_write(m_write),
        .m_raddr(m_raddr), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .m_rd_done(m_rd_done), .m_rdata(m_rdata),
        .m_wr_done(m_wr_done), .m_resp(m_resp),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Winner chosen by the arbitration rule.
    function automatic bit pick(input bit r0, input bit r1);
`ifdef ARB_ROUND_ROBIN_EN
        if (r0 && r1) return ~last_m;
`endif
        return r0 ? 1'b0 : 1'b1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},  {gnt0, gnt1}, 0);
        check({tag, "_done"}, {done0, done1}, 0);
        check({tag, "_data"}, {rdata, resp}, 0);
        check({tag, "_cmd"},  {m_read, m_write, m_raddr, m_waddr, m_wdata}, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // One transaction. Called at a negedge with the DUT idle.
    // dly: cycle (0 = the m_* pulse cycle) in which the master completes;
    // dly >= TO means the master never answers.
    task automatic run_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                           input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input int dly, input logic [7:0] rd, input logic [3:0] br,
                           input bit hold);
        bit         win, we, tmo;
        logic [7:0] a, d;
        int         exp_idx;
        win = pick(r0, r1);
        we  = win ? w1 : w0;
        a   = win ? a1 : a0;
        d   = win ? d1 : d0;
        tmo = (dly >= TO);
        exp_idx = tmo ? TO - 1 : dly;

        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        @(negedge clk);
        check("gnt0", gnt0, !win);
        check("gnt1", gnt1, win);
        check("busy", busy, 1);
        check("no_cmd_yet", {m_read, m_write}, 0);
        last_m = win;
        // Post-grant input changes must not leak into the command.
        we0 = $urandom; we1 = $urandom;
        addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
        @(negedge clk);
        check("m_read", m_read, !we);
        check("m_write", m_write, we);
        check("m_raddr", m_raddr, we ? 8'h00 : a);
        check("m_waddr", m_waddr, we ? a : 8'h00);
        check("m_wdata", m_wdata, we ? d : 8'h00);
        for (int i = 0; i <= exp_idx; i++) begin
            m_rdata = $urandom; m_resp = $urandom;
            if (i == dly) begin
                m_rd_done = !we; m_wr_done = we; m_rdata = rd; m_resp = br;
            end else begin
                // Completion of the wrong kind is noise.
                m_rd_done = we & 1'($urandom_range(0, 1));
                m_wr_done = !we & 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            m_rd_done = 1'b0; m_wr_done = 1'b0;
            check("one_pulse", {m_read, m_write}, 0);
            if (i == exp_idx) begin
                check("done0", done0, !win);
                check("done1", done1, win);
                check("rdata", rdata, (tmo || we) ? 8'h00 : rd);
                check("resp", resp, tmo ? TRSP : (we ? br : 4'h0));
            end else begin
                check("early_done", {done0, done1}, 0);
            end
        end
        if (!hold) begin req0 = 1'b0; req1 = 1'b0; end
        @(negedge clk);
        check("done_clr", {done0, done1}, 0);
        check("gnt_clr", {gnt0, gnt1}, 0);
        check("rdata_clr", rdata, 0);
        check("resp_clr", resp, 0);
        check("busy_clr", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        m_rd_done = 0; m_wr_done = 0; m_rdata = 0; m_resp = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Completion pulses while idle are ignored.
        m_rd_done = 1'b1; m_wr_done = 1'b1; m_rdata = 8'h77;
        @(negedge clk);
        m_rd_done = 1'b0; m_wr_done = 1'b0;
        check("idle_stray", {done0, done1, busy}, 0);

        // Port 0 read, completion two cycles after the command.
        run_txn(1, 0, 0, 0, 8'h12, 8'h00, 8'h00, 8'h00, 2, 8'hA5, 4'h0, 0);
        // Port 1 write.
        run_txn(0, 1, 0, 1, 8'h00, 8'h34, 8'h00, 8'h5C, 1, 8'h00, 4'h2, 0);
        // Fastest completion.
        run_txn(1, 0, 1, 0, 8'h9A, 8'h00, 8'h11, 8'h00, 0, 8'h00, 4'h1, 0);
        // Timeout.
        run_txn(1, 0, 0, 0, 8'h40, 8'h00, 8'h00, 8'h00, 20, 8'hEE, 4'h3, 0);
        // Completion on the same cycle the timer expires.
        run_txn(1, 0, 0, 0, 8'h41, 8'h00, 8'h00, 8'h00, TO - 1, 8'h3C, 4'h0, 0);

        // Reset in the middle of WAIT.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h55;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_wait");
        rst = 1'b0; req0 = 1'b0;
        last_m = 1'b1;
        m_rd_done = 1'b1; m_rdata = 8'h99;
        @(negedge clk);
        m_rd_done = 1'b0;
        check("post_rst_stray", {done0, done1, busy}, 0);
        repeat (2) @(negedge clk);
        check("post_rst_quiet", {done0, done1, gnt0, gnt1}, 0);

        // Both ports held high continuously.
        for (int k = 0; k < 4; k++)
            run_txn(1, 1, 0, 0, 8'h20, 8'h21, 8'h00, 8'h00, 0, 8'(8'h60 + k), 4'h0, 1);
        req0 = 1'b0; req1 = 1'b0;

        // Random traffic.
        for (int k = 0; k < 40; k++) begin
            bit r0, r1;
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(r0, r1, 1'($urandom), 1'($urandom),
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, TO + 3)), 8'($urandom), 4'($urandom), 1'($urandom));
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
